// File: rtl/tlc_phase_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tlc_phase_arbiter_pkg
// Shared types and constants for the intersection phase arbiter.
//   phase_t      : phase codes offered to the light sequencer
//   arb_state_t  : arbiter FSM states
//   PH_LANES     : lane mask served by each phase
//                  (lane bits: [0]e_str [1]w_str [2]e_left [3]w_left [4]ns)
//   phase_lanes(): PH_LANES lookup that is safe for out-of-range codes
// -----------------------------------------------------------------------------
package tlc_phase_arbiter_pkg;

  localparam int NUM_PHASES = 5;

  typedef enum logic [2:0] {
    PH_STR  = 3'd0,
    PH_EAST = 3'd1,
    PH_WEST = 3'd2,
    PH_LEFT = 3'd3,
    PH_NS   = 3'd4
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFER  = 2'd1,
    ST_ACTIVE = 2'd2
  } arb_state_t;

  localparam logic [4:0] PH_LANES [5] = '{
    5'b00011,   // STR : e_str, w_str
    5'b00101,   // EAST: e_str, e_left
    5'b01010,   // WEST: w_str, w_left
    5'b01100,   // LEFT: e_left, w_left
    5'b10000    // NS  : ns
  };

  // Codes above 4 map to an empty lane mask so they can never clear lanes.
  function automatic logic [4:0] phase_lanes(input logic [2:0] ph);
    logic [4:0] m;
    case (ph)
      3'd0:    m = PH_LANES[0];
      3'd1:    m = PH_LANES[1];
      3'd2:    m = PH_LANES[2];
      3'd3:    m = PH_LANES[3];
      3'd4:    m = PH_LANES[4];
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tlc_phase_arbiter_rr_pick5.sv
// -----------------------------------------------------------------------------
// rr_pick5
// Combinational 5-way round-robin picker. Searches req starting at
// (ptr+1) mod 5 and wrapping upward; returns the first set index.
//   req_i     [4:0] request vector
//   ptr_i     [2:0] last-served index (values above 4 are treated as 4)
//   gnt_idx_o [2:0] winning index (0 when nothing is requested)
//   any_o           at least one request is set
// With ptr_i = 4 the search starts at 0, i.e. plain lowest-index-first.
// -----------------------------------------------------------------------------
module rr_pick5 (
  input  logic [4:0] req_i,
  input  logic [2:0] ptr_i,
  output logic [2:0] gnt_idx_o,
  output logic       any_o
);

  // Walk the five candidate positions in rotated order, keep the first hit.
  always_comb begin
    logic [3:0] base_s;
    logic [3:0] idx_s;
    gnt_idx_o = 3'd0;
    any_o     = 1'b0;
    idx_s     = 4'd0;
    if (ptr_i > 3'd4) begin
      base_s = 4'd4;
    end else begin
      base_s = {1'b0, ptr_i};
    end
    for (int k = 1; k <= 5; k++) begin
      idx_s = base_s + 4'(k);
      if (idx_s >= 4'd5) begin
        idx_s = idx_s - 4'd5;
      end else begin
        idx_s = idx_s;
      end
      if (!any_o && req_i[idx_s[2:0]]) begin
        any_o     = 1'b1;
        gnt_idx_o = idx_s[2:0];
      end else begin
        any_o     = any_o;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_arbiter.sv
// -----------------------------------------------------------------------------
// tlc_phase_arbiter
// Chooses the next intersection phase and offers it to the light sequencer
// over a valid/ready handshake. Lane requests are latched until served,
// phases are arbitrated round-robin with anti-starvation aging, and an
// emergency preempt jumps the queue without aborting the running phase.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   sensor_i     [4:0] lane sensors [0]e_str [1]w_str [2]e_left [3]w_left [4]ns
//   preempt_valid_i    emergency request (sampled every cycle)
//   preempt_phase_i    requested phase; codes > 4 ignored
//   grant_valid_o      offered phase is valid (OFFER state)
//   grant_phase_o      offered phase code, stable while offered
//   grant_ready_i      sequencer accepts the offer
//   phase_done_i       sequencer finished the accepted phase (1-cycle pulse)
//   busy_o             high in OFFER and ACTIVE
//   starve_alarm_o     some phase wait counter sits at MAX_WAIT
// -----------------------------------------------------------------------------
module tlc_phase_arbiter
  import tlc_phase_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 40,
  parameter int NPH      = NUM_PHASES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] sensor_i,
  input  logic       preempt_valid_i,
  input  logic [2:0] preempt_phase_i,
  output logic       grant_valid_o,
  output logic [2:0] grant_phase_o,
  input  logic       grant_ready_i,
  input  logic       phase_done_i,
  output logic       busy_o,
  output logic       starve_alarm_o
);

  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  arb_state_t state_q, state_d;
  logic [4:0] pend_q, pend_d;
  logic [7:0] wait_q [NPH];
  logic [7:0] wait_d [NPH];
  logic       pre_pend_q, pre_pend_d;
  phase_t     pre_code_q, pre_code_d;
  logic       pre_offer_q, pre_offer_d;   // current offer came from the preempt latch
  phase_t     active_q, active_d;
  logic [2:0] ptr_q, ptr_d;
  phase_t     grant_phase_q, grant_phase_d;
  logic       grant_valid_q;
  logic       busy_q;
  logic       alarm_q, alarm_d;

  logic [4:0] preq_s;
  logic [4:0] starved_s;
  logic [2:0] rr_idx_s, st_idx_s;
  logic       rr_any_s, st_any_s;
  phase_t     sel_s;
  logic       accept_s, done_s, pre_set_s;

  // Phase requests and starved set, derived from latched lanes and counters.
  always_comb begin
    preq_s    = 5'b00000;
    starved_s = 5'b00000;
    for (int p = 0; p < NPH; p++) begin
      preq_s[p]    = |(pend_q & phase_lanes(3'(p)));
      // Gate by preq: a counter lags one cycle behind a lane clear.
      starved_s[p] = preq_s[p] && (wait_q[p] == MAX_W8);
    end
  end

  rr_pick5 u_rr_pick (
    .req_i     (preq_s),
    .ptr_i     (ptr_q),
    .gnt_idx_o (rr_idx_s),
    .any_o     (rr_any_s)
  );

  rr_pick5 u_starve_pick (
    .req_i     (starved_s),
    .ptr_i     (3'd4),
    .gnt_idx_o (st_idx_s),
    .any_o     (st_any_s)
  );

  // Selection priority: preempt, then lowest starved phase, then round-robin.
  always_comb begin
    if (pre_pend_q) begin
      sel_s = pre_code_q;
    end else if (st_any_s) begin
      sel_s = phase_t'(st_idx_s);
    end else begin
      sel_s = phase_t'(rr_idx_s);
    end
  end

  assign pre_set_s = preempt_valid_i && (preempt_phase_i <= 3'd4);

  // FSM next state plus the registers that change on handshake events.
  always_comb begin
    state_d       = state_q;
    grant_phase_d = grant_phase_q;
    active_d      = active_q;
    ptr_d         = ptr_q;
    pre_offer_d   = pre_offer_q;
    accept_s      = 1'b0;
    done_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pre_pend_q || rr_any_s) begin
          state_d       = ST_OFFER;
          grant_phase_d = sel_s;
          pre_offer_d   = pre_pend_q;
        end else begin
          state_d       = ST_IDLE;
        end
      end
      ST_OFFER: begin
        // A newer preempt must survive acceptance of the older one.
        if (pre_set_s) begin
          pre_offer_d = 1'b0;
        end else begin
          pre_offer_d = pre_offer_q;
        end
        if (grant_ready_i) begin
          state_d  = ST_ACTIVE;
          active_d = grant_phase_q;
          ptr_d    = grant_phase_q;
          accept_s = 1'b1;
        end else begin
          state_d  = ST_OFFER;
        end
      end
      ST_ACTIVE: begin
        if (phase_done_i) begin
          state_d = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Lane latch (set beats clear) and preempt latch (new request beats clear).
  always_comb begin
    if (done_s) begin
      pend_d = (pend_q & ~phase_lanes(active_q)) | sensor_i;
    end else begin
      pend_d = pend_q | sensor_i;
    end
    pre_pend_d = pre_pend_q;
    pre_code_d = pre_code_q;
    if (accept_s && pre_offer_q) begin
      pre_pend_d = 1'b0;
    end else begin
      pre_pend_d = pre_pend_q;
    end
    if (pre_set_s) begin
      pre_pend_d = 1'b1;
      pre_code_d = phase_t'(preempt_phase_i);
    end else begin
      pre_code_d = pre_code_q;
    end
  end

  // Aging counters; the alarm is computed from next-state so it tracks wait_q.
  always_comb begin
    alarm_d = 1'b0;
    for (int p = 0; p < NPH; p++) begin
      if ((accept_s && (grant_phase_q == 3'(p))) || !preq_s[p]) begin
        wait_d[p] = 8'd0;
      end else if ((state_q == ST_ACTIVE) && (active_q == 3'(p))) begin
        wait_d[p] = wait_q[p];
      end else if (wait_q[p] < MAX_W8) begin
        wait_d[p] = wait_q[p] + 8'd1;
      end else begin
        wait_d[p] = MAX_W8;
      end
      if (wait_d[p] == MAX_W8) begin
        alarm_d = 1'b1;
      end else begin
        alarm_d = alarm_d;
      end
    end
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pend_q        <= 5'b00000;
      pre_pend_q    <= 1'b0;
      pre_code_q    <= PH_STR;
      pre_offer_q   <= 1'b0;
      active_q      <= PH_STR;
      ptr_q         <= 3'd4;
      grant_phase_q <= PH_STR;
      grant_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      alarm_q       <= 1'b0;
      for (int p = 0; p < NPH; p++) begin
        wait_q[p] <= 8'd0;
      end
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      pre_pend_q    <= pre_pend_d;
      pre_code_q    <= pre_code_d;
      pre_offer_q   <= pre_offer_d;
      active_q      <= active_d;
      ptr_q         <= ptr_d;
      grant_phase_q <= grant_phase_d;
      grant_valid_q <= (state_d == ST_OFFER);
      busy_q        <= (state_d != ST_IDLE);
      alarm_q       <= alarm_d;
      for (int p = 0; p < NPH; p++) begin
        wait_q[p] <= wait_d[p];
      end
    end
  end

  assign grant_valid_o  = grant_valid_q;
  assign grant_phase_o  = grant_phase_q;
  assign busy_o         = busy_q;
  assign starve_alarm_o = alarm_q;

endmodule
